// File: rtl/ena_mrk_pkg.sv
// ena_mrk_pkg
// Shared types for the enable/mark bitmap controller:
//   req_op_e     - host operation encoding carried on req_op
//   ctrl_state_e - sweep controller state
//   grant_e      - which requester owned the bitmap write port last sweep cycle
package ena_mrk_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_SET   = 2'd1,
    OP_CLR   = 2'd2,
    OP_TOUCH = 2'd3
  } req_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } ctrl_state_e;

  typedef enum logic {
    GNT_HOST  = 1'b0,
    GNT_SWEEP = 1'b1
  } grant_e;

endpackage

// File: rtl/ena_mrk_row_update.sv
// ena_mrk_row_update
// Purely combinational next-value logic for one bitmap row. The host path
// edits a single (col) bit according to op; the sweep path ages the whole
// word and reports which columns expired.
// Ports:
//   ena, mrk  in   current row words
//   op        in   host operation (ignored when is_sweep)
//   col       in   host target column (ignored when is_sweep)
//   is_sweep  in   1 = apply the aging rule to the whole word
//   ena_n     out  next enable word
//   mrk_n     out  next mark word
//   exp       out  expired columns (only non-zero on the sweep path)
module ena_mrk_row_update
  import ena_mrk_pkg::*;
#(
  parameter int NCOLS = 16,
  localparam int CW = $clog2(NCOLS)
) (
  input  logic [NCOLS-1:0] ena,
  input  logic [NCOLS-1:0] mrk,
  input  req_op_e          op,
  input  logic [CW-1:0]    col,
  input  logic             is_sweep,
  output logic [NCOLS-1:0] ena_n,
  output logic [NCOLS-1:0] mrk_n,
  output logic [NCOLS-1:0] exp
);

  // Sweep: a column that was already marked and is still enabled has seen a
  // full interval without a touch, so it expires. Survivors get re-marked so
  // they expire next sweep unless the host touches them first.
  // Host ops only ever clear the mark; SET/CLR also write the enable.
  always_comb begin
    ena_n = ena;
    mrk_n = mrk;
    exp   = '0;
    if (is_sweep) begin
      exp   = ena & mrk;
      ena_n = ena & ~mrk;
      mrk_n = ena & ~mrk;
    end else begin
      case (op)
        OP_SET: begin
          ena_n[col] = 1'b1;
          mrk_n[col] = 1'b0;
        end
        OP_CLR: begin
          ena_n[col] = 1'b0;
          mrk_n[col] = 1'b0;
        end
        OP_TOUCH: begin
          mrk_n[col] = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ena_mrk_sweep_ctrl.sv
// ena_mrk_sweep_ctrl
// Sole writer of the NROWS x NCOLS enable/mark bitmap. Host set/clear/touch
// requests share the single row write port with a periodic timeout sweep
// that ages one row per grant and reports expired columns.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/ready/op/row/col      host operation handshake
//   tick                            starts a sweep when idle
//   exp_valid/ready/row/mask        expired-column report handshake
//   rd_row -> rd_ena/rd_mrk         registered status read (1-cycle latency)
//   busy                            sweep in progress
//   tick_miss, miss_clr             sticky dropped-tick flag and its clear
module ena_mrk_sweep_ctrl
  import ena_mrk_pkg::*;
#(
  parameter int NROWS = 16,
  parameter int NCOLS = 16,
  localparam int RW = $clog2(NROWS),
  localparam int CW = $clog2(NCOLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [RW-1:0]    req_row,
  input  logic [CW-1:0]    req_col,
  input  logic             tick,
  output logic             exp_valid,
  input  logic             exp_ready,
  output logic [RW-1:0]    exp_row,
  output logic [NCOLS-1:0] exp_mask,
  input  logic [RW-1:0]    rd_row,
  output logic [NCOLS-1:0] rd_ena,
  output logic [NCOLS-1:0] rd_mrk,
  output logic             busy,
  output logic             tick_miss,
  input  logic             miss_clr
);

  logic [NCOLS-1:0] ena_q [NROWS];
  logic [NCOLS-1:0] mrk_q [NROWS];
  logic [NCOLS-1:0] ena_d [NROWS];
  logic [NCOLS-1:0] mrk_d [NROWS];

  ctrl_state_e   state_q, state_d;
  grant_e        last_grant_q;
  logic [RW-1:0] ptr_q;

  logic             exp_free;
  logic             grant_sweep;
  logic             host_fire;
  logic             wr_en;
  logic [RW-1:0]    upd_row;
  logic [NCOLS-1:0] upd_ena, upd_mrk, upd_exp;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a tick starts a sweep, the grant that ages the last row ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_SWEEP;
      ST_SWEEP: if (grant_sweep && ptr_q == RW'(NROWS - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Arbitration and handshake outputs. The sweep only takes the write port
  // when it can also park a possible report, and it yields to a waiting host
  // if it had the previous cycle, so the host is never shut out for two
  // consecutive cycles.
  always_comb begin
    exp_free    = !exp_valid || exp_ready;
    grant_sweep = 1'b0;
    if (state_q == ST_SWEEP)
      grant_sweep = (!req_valid || last_grant_q == GNT_HOST) && exp_free;
    req_ready = !grant_sweep;
    host_fire = req_valid && req_ready;
    busy      = (state_q == ST_SWEEP);
  end

  // One shared row-update path; sweep and host grants are mutually exclusive.
  always_comb begin
    upd_row = grant_sweep ? ptr_q : req_row;
    wr_en   = grant_sweep || host_fire;
  end

  ena_mrk_row_update #(.NCOLS(NCOLS)) u_row_update (
    .ena      (ena_q[upd_row]),
    .mrk      (mrk_q[upd_row]),
    .op       (req_op_e'(req_op)),
    .col      (req_col),
    .is_sweep (grant_sweep),
    .ena_n    (upd_ena),
    .mrk_n    (upd_mrk),
    .exp      (upd_exp)
  );

  // Next bitmap image. Kept as a full array so the status read can return
  // the post-write value of any row without a separate bypass path.
  always_comb begin
    for (int i = 0; i < NROWS; i++) begin
      ena_d[i] = ena_q[i];
      mrk_d[i] = mrk_q[i];
    end
    if (wr_en) begin
      ena_d[upd_row] = upd_ena;
      mrk_d[upd_row] = upd_mrk;
    end
  end

  // Bitmap storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NROWS; i++) begin
      if (!rst_n) begin
        ena_q[i] <= '0;
        mrk_q[i] <= '0;
      end else begin
        ena_q[i] <= ena_d[i];
        mrk_q[i] <= mrk_d[i];
      end
    end
  end

  // Row pointer and round-robin memory. last_grant only tracks decisions
  // made while sweeping; idle cycles are not contested.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      last_grant_q <= GNT_HOST;
    end else if (state_q == ST_IDLE) begin
      if (tick) ptr_q <= '0;
    end else if (grant_sweep) begin
      last_grant_q <= GNT_SWEEP;
      ptr_q        <= (ptr_q == RW'(NROWS - 1)) ? '0 : ptr_q + RW'(1);
    end else begin
      last_grant_q <= GNT_HOST;
    end
  end

  // Expired-column report. A new report may be loaded on the same edge the
  // previous one is consumed; rows with nothing expired never raise valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_row   <= '0;
      exp_mask  <= '0;
    end else if (grant_sweep && |upd_exp) begin
      exp_valid <= 1'b1;
      exp_row   <= ptr_q;
      exp_mask  <= upd_exp;
    end else if (exp_valid && exp_ready) begin
      exp_valid <= 1'b0;
    end
  end

  // Status read returns the row as it stands after this edge's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ena <= '0;
      rd_mrk <= '0;
    end else begin
      rd_ena <= ena_d[rd_row];
      rd_mrk <= mrk_d[rd_row];
    end
  end

  // Sticky dropped-tick flag; a new miss beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n)                         tick_miss <= 1'b0;
    else if (tick && state_q == ST_SWEEP) tick_miss <= 1'b1;
    else if (miss_clr)                  tick_miss <= 1'b0;
  end

endmodule

// File: tb/tb_ena_mrk_sweep_ctrl.sv
// tb_ena_mrk_sweep_ctrl
// Self-checking bench for ena_mrk_sweep_ctrl: a table of host-op vectors,
// hand-written multi-cycle scenarios, and a randomized phase, all compared
// every cycle against a behavioural bitmap model.
module tb_ena_mrk_sweep_ctrl;
  import ena_mrk_pkg::*;

  localparam int NROWS = 16;
  localparam int NCOLS = 16;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, tick, exp_valid, exp_ready;
  logic        busy, tick_miss, miss_clr;
  logic [1:0]  req_op;
  logic [3:0]  req_row, req_col, exp_row, rd_row;
  logic [15:0] exp_mask, rd_ena, rd_mrk;

  always #5 clk = ~clk;

  ena_mrk_sweep_ctrl #(.NROWS(NROWS), .NCOLS(NCOLS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_row   (req_row),
    .req_col   (req_col),
    .tick      (tick),
    .exp_valid (exp_valid),
    .exp_ready (exp_ready),
    .exp_row   (exp_row),
    .exp_mask  (exp_mask),
    .rd_row    (rd_row),
    .rd_ena    (rd_ena),
    .rd_mrk    (rd_mrk),
    .busy      (busy),
    .tick_miss (tick_miss),
    .miss_clr  (miss_clr)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural model of the table and the controller's visible state.
  bit [15:0] mEna [NROWS];
  bit [15:0] mMrk [NROWS];
  bit        mBusy, mLastSweep, mExpValid, mMiss;
  int        mPtr;
  bit [3:0]  mExpRow;
  bit [15:0] mExpMask, mRdEna, mRdMrk;

  bit          sampledReady;
  logic [3:0]  hsRow [$];
  logic [15:0] hsMask [$];

  typedef struct {
    bit        rv;
    bit [1:0]  op;
    bit [3:0]  row;
    bit [3:0]  col;
    bit        tk;
    bit        er;
    bit [3:0]  rdr;
    bit        expReady;
    bit        expBusy;
    bit        expValid;
    bit [15:0] expRdEna;
    bit [15:0] expRdMrk;
  } vec_t;

  vec_t vecs [6];

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, act, expv);
    end
  endtask

  // Reset image of the model.
  task automatic modelReset();
    for (int i = 0; i < NROWS; i++) begin
      mEna[i] = '0;
      mMrk[i] = '0;
    end
    mBusy = 0; mLastSweep = 0; mExpValid = 0; mMiss = 0; mPtr = 0;
    mExpRow = '0; mExpMask = '0; mRdEna = '0; mRdMrk = '0;
  endtask

  // Would the sweep own this cycle, given the current inputs?
  function automatic bit modelGrant();
    return mBusy && (!req_valid || !mLastSweep) && (!mExpValid || exp_ready);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit        g, hostFire, wasBusy;
    bit [15:0] e;
    if (!rst_n) begin
      modelReset();
      return;
    end
    g        = modelGrant();
    hostFire = req_valid && !g;
    wasBusy  = mBusy;
    if (mExpValid && exp_ready) mExpValid = 0;
    if (hostFire) begin
      case (req_op)
        2'd1: begin mEna[req_row][req_col] = 1'b1; mMrk[req_row][req_col] = 1'b0; end
        2'd2: begin mEna[req_row][req_col] = 1'b0; mMrk[req_row][req_col] = 1'b0; end
        2'd3: mMrk[req_row][req_col] = 1'b0;
        default: ;
      endcase
    end
    if (g) begin
      e = mEna[mPtr] & mMrk[mPtr];
      mEna[mPtr] = mEna[mPtr] & ~mMrk[mPtr];
      mMrk[mPtr] = mEna[mPtr];
      if (e != 0) begin
        mExpValid = 1;
        mExpRow   = 4'(mPtr);
        mExpMask  = e;
      end
      mPtr = (mPtr + 1) % NROWS;
      if (mPtr == 0) mBusy = 0;
      mLastSweep = 1;
    end else if (wasBusy) begin
      mLastSweep = 0;
    end
    if (tick && wasBusy) mMiss = 1;
    else if (miss_clr)   mMiss = 0;
    if (tick && !wasBusy) begin
      mBusy = 1;
      mPtr  = 0;
    end
    mRdEna = mEna[rd_row];
    mRdMrk = mMrk[rd_row];
  endtask

  // Drive one cycle of inputs, check the combinational ready before the
  // edge and all registered outputs after it.
  task automatic applyStimulus(input bit rst, input bit rv, input bit [1:0] op,
                               input bit [3:0] row, input bit [3:0] col, input bit tk,
                               input bit er, input bit [3:0] rdr, input bit mc);
    rst_n = rst; req_valid = rv; req_op = op; req_row = row; req_col = col;
    tick = tk; exp_ready = er; rd_row = rdr; miss_clr = mc;
    #1;
    sampledReady = req_ready;
    checkOutput("req_ready", req_ready, modelGrant() ? 0 : 1);
    if (exp_valid && exp_ready) begin
      hsRow.push_back(exp_row);
      hsMask.push_back(exp_mask);
    end
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("exp_valid", exp_valid, mExpValid);
    checkOutput("exp_row", exp_row, mExpRow);
    checkOutput("exp_mask", exp_mask, mExpMask);
    checkOutput("busy", busy, mBusy);
    checkOutput("tick_miss", tick_miss, mMiss);
    checkOutput("rd_ena", rd_ena, mRdEna);
    checkOutput("rd_mrk", rd_mrk, mRdMrk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int reports;
    int busyCycles;
    int accepted;
    logic [3:0]  lastRow;
    logic [15:0] lastMask;

    rst_n = 0; req_valid = 0; req_op = '0; req_row = '0; req_col = '0;
    tick = 0; exp_ready = 0; rd_row = '0; miss_clr = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    modelReset();

    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_exp_valid", exp_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tick_miss", tick_miss, 0);
    checkOutput("reset_rd_ena", rd_ena, 16'h0000);

    // Host-op vectors from the cleared table.
    vecs[0] = '{1, OP_SET,   3, 5, 0, 1, 3, 1, 0, 0, 16'h0020, 16'h0000};
    vecs[1] = '{1, OP_SET,   3, 9, 0, 1, 3, 1, 0, 0, 16'h0220, 16'h0000};
    vecs[2] = '{1, OP_TOUCH, 3, 9, 0, 1, 3, 1, 0, 0, 16'h0220, 16'h0000};
    vecs[3] = '{1, OP_SET,   7, 2, 0, 1, 7, 1, 0, 0, 16'h0004, 16'h0000};
    vecs[4] = '{1, OP_NOP,   7, 2, 0, 1, 7, 1, 0, 0, 16'h0004, 16'h0000};
    vecs[5] = '{0, OP_NOP,   0, 0, 1, 1, 3, 1, 1, 0, 16'h0220, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, vecs[i].rv, vecs[i].op, vecs[i].row, vecs[i].col,
                    vecs[i].tk, vecs[i].er, vecs[i].rdr, 0);
      checkOutput("vec_ready", sampledReady, vecs[i].expReady);
      checkOutput("vec_busy", busy, vecs[i].expBusy);
      checkOutput("vec_exp_valid", exp_valid, vecs[i].expValid);
      checkOutput("vec_rd_ena", rd_ena, vecs[i].expRdEna);
      checkOutput("vec_rd_mrk", rd_mrk, vecs[i].expRdMrk);
    end

    // First sweep only marks: no reports, survivors marked.
    reports = 0;
    for (int k = 0; k < NROWS; k++) begin
      applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 3, 0);
      if (exp_valid) reports++;
    end
    checkOutput("sweep1_reports", reports, 0);
    checkOutput("sweep1_done", busy, 0);
    applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 3, 0);
    checkOutput("row3_ena_marked", rd_ena, 16'h0220);
    checkOutput("row3_mrk_marked", rd_mrk, 16'h0220);

    // Clearing a marked bit must keep row 7 out of the next sweep's reports.
    applyStimulus(1, 1, OP_CLR, 7, 2, 0, 1, 7, 0);
    checkOutput("row7_ena_clr", rd_ena, 16'h0000);
    checkOutput("row7_mrk_clr", rd_mrk, 16'h0000);

    // Second sweep: row 3 expires, nothing else.
    reports = 0; lastRow = '0; lastMask = '0;
    applyStimulus(1, 0, OP_NOP, 0, 0, 1, 1, 3, 0);
    for (int k = 0; k < NROWS; k++) begin
      applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 3, 0);
      if (exp_valid) begin
        reports++;
        lastRow = exp_row;
        lastMask = exp_mask;
      end
    end
    checkOutput("sweep2_reports", reports, 1);
    checkOutput("sweep2_row", lastRow, 3);
    checkOutput("sweep2_mask", lastMask, 16'h0220);
    checkOutput("row3_ena_expired", rd_ena, 16'h0000);
    checkOutput("row3_mrk_expired", rd_mrk, 16'h0000);

    // Continuous host traffic during a sweep: strict alternation.
    busyCycles = 0; accepted = 0;
    applyStimulus(1, 1, OP_SET, 4'($urandom), 4'($urandom), 1, 1, 0, 0);
    if (busy) busyCycles++;
    for (int k = 0; k < 80 && busy; k++) begin
      applyStimulus(1, 1, OP_SET, 4'($urandom), 4'($urandom), 0, 1, 4'($urandom), 0);
      checkOutput("ready_alternates", sampledReady, (k % 2 == 0) ? 1 : 0);
      if (sampledReady) accepted++;
      if (busy) busyCycles++;
    end
    checkOutput("busy_cycles", busyCycles, 2 * NROWS);
    checkOutput("host_ops_accepted", accepted, NROWS);

    // Back-pressure: rows 0..2 fully marked, report held while exp_ready low.
    applyStimulus(0, 0, OP_NOP, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCOLS; c++)
        applyStimulus(1, 1, OP_SET, 4'(r), 4'(c), 0, 1, 4'(r), 0);
    applyStimulus(1, 0, OP_NOP, 0, 0, 1, 1, 1, 0);
    for (int k = 0; k < NROWS; k++)
      applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 1, 0);
    checkOutput("row1_full_mrk", rd_mrk, 16'hFFFF);
    applyStimulus(1, 0, OP_NOP, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      applyStimulus(1, 1, OP_NOP, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1, OP_NOP, 0, 0, 0, 0, 0, 0);
      checkOutput("stall_host_ready", sampledReady, 1);
      checkOutput("stall_exp_valid", exp_valid, 1);
      checkOutput("stall_exp_row", exp_row, 0);
      checkOutput("stall_exp_mask", exp_mask, 16'hFFFF);
    end
    hsRow.delete();
    hsMask.delete();
    for (int k = 0; k < 40 && busy; k++)
      applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 0, 0);
    checkOutput("release_done", busy, 0);
    checkOutput("release_reports", hsRow.size(), 3);
    for (int i = 0; i < 3 && i < hsRow.size(); i++) begin
      checkOutput("release_row", hsRow[i], i);
      checkOutput("release_mask", hsMask[i], 16'hFFFF);
    end

    // Ticks mid-sweep (with a simultaneous clear) and on the final cycle.
    applyStimulus(1, 0, OP_NOP, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= NROWS; k++) begin
      applyStimulus(1, 0, OP_NOP, 0, 0, (k == 8 || k == NROWS), 1, 0, (k == 8));
      if (k == 8) checkOutput("miss_set_wins", tick_miss, 1);
    end
    checkOutput("last_tick_done", busy, 0);
    checkOutput("last_tick_miss", tick_miss, 1);
    applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 0, 0);
    checkOutput("no_second_sweep", busy, 0);
    applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 0, 1);
    checkOutput("miss_cleared", tick_miss, 0);

    // Reset in the middle of a sweep with a report pending.
    applyStimulus(1, 1, OP_SET, 5, 1, 0, 1, 5, 0);
    applyStimulus(1, 0, OP_NOP, 0, 0, 1, 1, 5, 0);
    for (int k = 0; k < NROWS; k++)
      applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 5, 0);
    applyStimulus(1, 0, OP_NOP, 0, 0, 1, 0, 5, 0);
    for (int k = 0; k < 20 && !exp_valid; k++)
      applyStimulus(1, 0, OP_NOP, 0, 0, 0, 0, 5, 0);
    checkOutput("pre_reset_exp_valid", exp_valid, 1);
    checkOutput("pre_reset_exp_row", exp_row, 5);
    applyStimulus(0, 0, OP_NOP, 0, 0, 0, 0, 5, 0);
    checkOutput("midreset_exp_valid", exp_valid, 0);
    checkOutput("midreset_busy", busy, 0);
    for (int r = 0; r < NROWS; r++) begin
      applyStimulus(1, 0, OP_NOP, 0, 0, 0, 1, 4'(r), 0);
      checkOutput("post_reset_rd_ena", rd_ena, 16'h0000);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 127) != 0), 1'($urandom), 2'($urandom),
                    4'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0),
                    1'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
